// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI (mode 0) slave in front of a small register bank.
//   The first word of a frame is a command: MSB=1 read, MSB=0 write; the low
//   p_ADDR_W bits give the start address. Each later word writes or reads
//   register[addr]. The address post-increments and wraps.
// Ports:
//   i_clk, i_rst               system clock, synchronous active-high reset
//   i_sclk, i_mosi, i_ss       SPI bus from master (asynchronous, ss active-low)
//   o_miso                     serial data to master (0 unless in a read frame)
//   o_wr_stb/o_wr_addr/o_wr_data  one-cycle notification of each register write
//   i_rd_addr / o_rd_data      combinational local read port
//   o_busy                     frame in progress (FSM not idle)
module spi_reg_slave #(
  parameter int p_WORD_LEN = 8,
  parameter int p_ADDR_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  output logic                  o_miso,
  output logic                  o_wr_stb,
  output logic [p_ADDR_W-1:0]   o_wr_addr,
  output logic [p_WORD_LEN-1:0] o_wr_data,
  input  logic [p_ADDR_W-1:0]   i_rd_addr,
  output logic [p_WORD_LEN-1:0] o_rd_data,
  output logic                  o_busy
);

  localparam int DEPTH  = 1 << p_ADDR_W;
  localparam int CNT_W  = (p_WORD_LEN > 1) ? $clog2(p_WORD_LEN) : 1;
  localparam int STAGES = 2;

  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(p_WORD_LEN - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [p_ADDR_W-1:0] ADDR_ONE = p_ADDR_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMD   = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] RDATA = 2'd3;

  // [0],[1] form the synchronizer; [2] is the previous synchronized sample
  logic [STAGES:0]   sclk_q, ss_q;
  logic [1:0]        mosi_q;
  // Marks how many synchronizer stages hold real pin samples since reset.
  // Edges are ignored until [STAGES] is set, so a frame that was already
  // running when reset hit cannot look like a fresh ss fall.
  logic [STAGES:0]   vld_pipe;

  logic [1:0]                      state;
  logic [CNT_W-1:0]                bit_cnt;
  logic [p_WORD_LEN-1:0]           rx_shift, tx_shift, rx_word;
  logic [p_ADDR_W-1:0]             addr;
  logic                            load_pend;
  logic [DEPTH-1:0][p_WORD_LEN-1:0] regs;

  logic sync_ok, sclk_rise, sclk_fall, ss_fall, ss_high, word_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_q   <= '0;
      ss_q     <= '1;
      mosi_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sclk_q   <= {sclk_q[STAGES-1:0], i_sclk};
      ss_q     <= {ss_q[STAGES-1:0], i_ss};
      mosi_q   <= {mosi_q[0], i_mosi};
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign sync_ok   = vld_pipe[STAGES];
  assign sclk_rise = sync_ok &  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = sync_ok & ~sclk_q[1] &  sclk_q[2];
  assign ss_fall   = sync_ok & ~ss_q[1]   &  ss_q[2];
  assign ss_high   = ss_q[1];
  assign rx_word   = {rx_shift[p_WORD_LEN-2:0], mosi_q[1]};
  assign word_done = sclk_rise & (bit_cnt == LAST_BIT) & (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      addr      <= '0;
      load_pend <= 1'b0;
      regs      <= '0;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_stb <= 1'b0;
      if (ss_high) begin
        // frame ended or aborted: any partial word is dropped
        state     <= IDLE;
        bit_cnt   <= '0;
        rx_shift  <= '0;
        tx_shift  <= '0;
        load_pend <= 1'b0;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          state    <= CMD;
          bit_cnt  <= '0;
          rx_shift <= '0;
        end
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_word;
          bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_ONE;
        end
        if (word_done) begin
          case (state)
            CMD: begin
              addr <= rx_word[p_ADDR_W-1:0];
              if (rx_word[p_WORD_LEN-1]) begin
                state     <= RDATA;
                load_pend <= 1'b1;
              end else begin
                state <= WDATA;
              end
            end
            WDATA: begin
              regs[addr] <= rx_word;
              o_wr_stb   <= 1'b1;
              o_wr_addr  <= addr;
              o_wr_data  <= rx_word;
              addr       <= addr + ADDR_ONE;
            end
            default: load_pend <= 1'b1;
          endcase
        end
        // The fall that closes a word loads the next read word so its MSB is
        // on MISO before the master's next rise; other falls just shift.
        if ((state == RDATA) && sclk_fall) begin
          if (load_pend) begin
            tx_shift  <= regs[addr];
            addr      <= addr + ADDR_ONE;
            load_pend <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[p_WORD_LEN-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_miso    = (state == RDATA) & tx_shift[p_WORD_LEN-1];
  assign o_busy    = (state != IDLE);
  assign o_rd_data = regs[i_rd_addr];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: an SPI master drives frames; expected write strobes
// and expected MISO words are queued from a transaction-level register model,
// and independent monitors pop and compare as the DUT produces them.
module tb_spi_reg_slave;
  localparam int W = 8;
  localparam int A = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, sclk, mosi, ss;
  logic         miso, wr_stb, busy;
  logic [A-1:0] wr_addr, rd_addr;
  logic [W-1:0] wr_data, rd_data;

  always #5 clk = ~clk;

  spi_reg_slave #(.p_WORD_LEN(W), .p_ADDR_W(A)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss(ss),
    .o_miso(miso), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int half  = 80;

  logic [W-1:0]   model [N];
  logic [A+W-1:0] exp_wr [$];
  logic [W-1:0]   exp_rd [$];
  logic [W-1:0]   rx_obs [$];
  logic [W-1:0]   wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // write-strobe monitor
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wr_stb_unexpected: got strobe addr 0x%0h data 0x%0h, expected none",
                 wr_addr, wr_data);
      end else begin
        logic [A+W-1:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[A+W-1:W]));
        chk("wr_data", 32'(wr_data), 32'(e[W-1:0]));
      end
    end
  end

  // MISO word monitor
  always @(negedge clk) begin
    while (rx_obs.size() > 0) begin
      logic [W-1:0] r;
      r = rx_obs.pop_front();
      if (exp_rd.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL miso_unexpected: got word 0x%0h, expected none", r);
      end else begin
        chk("miso_word", 32'(r), 32'(exp_rd.pop_front()));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic xfer(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    rx = '0;
    for (int i = W - 1; i >= W - nbits; i--) begin
      mosi = tx[i];
      #(half);
      sclk  = 1'b1;
      rx[i] = miso;
      #(half);
      sclk = 1'b0;
    end
  endtask

  // one frame: command word then wq.size() data words
  task automatic txn(input bit is_rd, input logic [A-1:0] addr);
    logic [W-1:0] cmd, rx;
    logic [A-1:0] a;
    cmd = '0;
    cmd[W-1]   = is_rd;
    cmd[A-1:0] = addr;
    ss = 1'b0;
    #(half);
    exp_rd.push_back('0);
    xfer(cmd, W, rx);
    rx_obs.push_back(rx);
    for (int i = 0; i < wq.size(); i++) begin
      a = addr + A'(i);
      if (is_rd) begin
        exp_rd.push_back(model[a]);
      end else begin
        exp_rd.push_back('0);
        exp_wr.push_back({a, wq[i]});
        model[a] = wq[i];
      end
      xfer(wq[i], W, rx);
      rx_obs.push_back(rx);
    end
    #(half);
    ss = 1'b1;
    settle(6);
    chk("busy_after_frame", 32'(busy), 32'd0);
  endtask

  task automatic check_rd_port(input string name);
    for (int a = 0; a < N; a++) begin
      rd_addr = A'(a);
      @(negedge clk);
      chk(name, 32'(rd_data), 32'(model[a]));
    end
    settle(1);
  endtask

  initial begin
    logic [W-1:0] rx;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 1'b1; rd_addr = '0;
    for (int i = 0; i < N; i++) model[i] = '0;

    // reset
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    check_rd_port("rst_rd_data");

    // single write then readback
    wq = {};
    wq.push_back(8'hA5);
    txn(1'b0, 4'h3);
    check_rd_port("wr_rd_data");
    wq = {};
    wq.push_back(8'h00);
    txn(1'b1, 4'h3);

    // burst write wrapping 15 -> 0, then burst read
    wq = {};
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    txn(1'b0, 4'hF);
    wq = {};
    wq.push_back(8'h00);
    wq.push_back(8'h00);
    txn(1'b1, 4'hF);
    check_rd_port("burst_rd_data");

    // abort mid-word
    ss = 1'b0;
    #(half);
    exp_rd.push_back('0);
    xfer(8'h05, W, rx);
    rx_obs.push_back(rx);
    xfer(8'hFF, 5, rx);
    #(half);
    ss = 1'b1;
    settle(6);
    chk("abort_busy", 32'(busy), 32'd0);
    rd_addr = 4'h5;
    @(negedge clk);
    chk("abort_reg5", 32'(rd_data), 32'(model[5]));
    settle(1);
    wq = {};
    wq.push_back(8'h3C);
    txn(1'b0, 4'h5);
    check_rd_port("post_abort_rd_data");

    // random frames
    for (int t = 0; t < 20; t++) begin
      bit is_rd;
      int n;
      half  = 10 * $urandom_range(6, 10);
      is_rd = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 4);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(W'($urandom));
      txn(is_rd, A'($urandom));
      if (t % 5 == 4) check_rd_port("rand_rd_data");
    end
    half = 80;

    // reset during bit 3 of a read data word
    ss = 1'b0;
    #(half);
    exp_rd.push_back('0);
    xfer(8'h83, W, rx);
    rx_obs.push_back(rx);
    xfer(8'h00, 3, rx);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrd_rst_miso", 32'(miso), 32'd0);
    chk("midrd_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = '0;
    settle(1);
    // bus keeps toggling with ss still low: must be ignored
    xfer(8'h01, W, rx);
    xfer(8'hFF, W, rx);
    chk("midrd_ignored_busy", 32'(busy), 32'd0);
    chk("midrd_ignored_miso", 32'(miso), 32'd0);
    #(half);
    ss = 1'b1;
    settle(6);
    check_rd_port("midrd_rd_data");
    wq = {};
    wq.push_back(8'h5A);
    txn(1'b0, 4'h9);
    wq = {};
    wq.push_back(8'h00);
    txn(1'b1, 4'h9);
    check_rd_port("final_rd_data");

    settle(4);
    chk("wr_pending", 32'(exp_wr.size()), 32'd0);
    chk("rd_pending", 32'(exp_rd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter p_WORD_LEN, default 8: SPI word length in bits, MSB first.
REQ-002 Parameter p_ADDR_W, default 4: register address width; register bank holds 2**p_ADDR_W words; p_ADDR_W SHALL be <= p_WORD_LEN-1.
REQ-003 i_clk  input  1  system clock; all state on rising edge.
REQ-004 i_rst  input  1  synchronous reset, active-high.
REQ-005 i_sclk  input  1  SPI clock from master, asynchronous to i_clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 i_mosi  input  1  serial data from master.
REQ-007 i_ss  input  1  slave select, active-low.
REQ-008 o_miso  output  1  serial data to master.
REQ-009 o_wr_stb  output  1  one-cycle pulse on each completed SPI register write.
REQ-010 o_wr_addr  output  p_ADDR_W  address of the write flagged by o_wr_stb.
REQ-011 o_wr_data  output  p_WORD_LEN  data of the write flagged by o_wr_stb.
REQ-012 i_rd_addr  input  p_ADDR_W  local read-port address.
REQ-013 o_rd_data  output  p_WORD_LEN  combinational register[i_rd_addr].
REQ-014 o_busy  output  1  high when the FSM is not in IDLE.

Function
REQ-015 i_sclk, i_mosi and i_ss SHALL each pass through a 2-flop synchronizer; SCLK rise/fall SHALL be detected from the synchronized samples; i_clk SHALL run at least 4x SCLK.
REQ-016 On each detected SCLK rise with ss low, MOSI SHALL shift into the RX shift register; a bit counter SHALL count 0..p_WORD_LEN-1 and wrap.
REQ-017 First word after ss falls = command: bit[p_WORD_LEN-1] 1=read, 0=write; bits[p_ADDR_W-1:0] = start address; other bits ignored.
REQ-018 FSM states: IDLE, CMD, WDATA, RDATA.
REQ-019 IDLE->CMD on synchronized ss falling; CMD->WDATA or RDATA on completion of the command word per the R/W bit; WDATA and RDATA self-loop per word; any state->IDLE when synchronized ss is high.
REQ-020 WDATA: each completed word SHALL write register[addr], pulse o_wr_stb for exactly one cycle with o_wr_addr/o_wr_data, then increment addr.
REQ-021 RDATA: register[addr] SHALL load into the TX shift register at the SCLK fall completing the previous word, MSB on o_miso before the next SCLK rise; subsequent bits SHALL shift on each SCLK fall; addr SHALL increment at each word load.
REQ-022 Address increment SHALL wrap from 2**p_ADDR_W-1 to 0.
REQ-023 o_miso SHALL be 0 in IDLE, CMD and WDATA.
REQ-024 Read-data value SHALL be sampled at load time; a write landing in the same cycle SHALL not affect the word already loaded.
REQ-025 ss rising mid-word SHALL discard the partial word: no o_wr_stb, no register change, bit counter cleared.
REQ-026 o_rd_data SHALL reflect an SPI write from the cycle after o_wr_stb.

Reset
REQ-027 i_rst SHALL force: FSM IDLE, bit counter 0, shift registers 0, address 0, all registers 0, o_miso 0, o_wr_stb 0, o_wr_addr 0, o_wr_data 0, o_busy 0, synchronizer flops to idle levels (sclk 0, ss 1).
REQ-028 i_rst mid-transaction SHALL abort it; block SHALL ignore the bus until ss is seen high then falls again.

Verification
REQ-029 Reset: assert i_rst 2 cycles -> o_miso=0, o_wr_stb=0, o_busy=0, o_rd_data=0 for all i_rd_addr.
REQ-030 Write: ss low, master sends 0x03, 0xA5 -> exactly one o_wr_stb with o_wr_addr=3, o_wr_data=0xA5; i_rd_addr=3 gives 0xA5.
REQ-031 Read: after REQ-030, ss low, master sends 0x83, 0x00 -> master receives 0x00 during word 1, 0xA5 during word 2; no o_wr_stb.
REQ-032 Burst wrap: ss low, master sends 0x0F, 0x11, 0x22 -> two strobes (addr 15 data 0x11, addr 0 data 0x22); reads 0x8F,0,0 return 0x11, 0x22.
REQ-033 Abort: ss low, send 0x05, then 5 bits of 0xFF, ss high -> no o_wr_stb, register 5 unchanged, o_busy=0; next write 0x05,0x3C succeeds.
REQ-034 Reset mid-read: i_rst during bit 3 of read data word -> o_miso=0 and o_busy=0 next cycle; no further activity until ss toggles high then low.
